// File: rtl/life_pkg.sv
// life_pkg: shared control-state encodings and the B3/S23 rule
package life_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PROGRAM = 2'b01,
    ST_RUN     = 2'b10,
    ST_PAUSE   = 2'b11
  } state_t;

  function automatic logic life_rule(input logic alive, input logic [3:0] count);
    return count == 4'd3 || (alive && count == 4'd2);
  endfunction
endpackage

// File: rtl/life_row_eval.sv
// life_row_eval: next state of one row from itself and its two vertical neighbours
module life_row_eval import life_pkg::*; #(
  parameter int COLS = 8,
  parameter bit WRAP = 1'b1
) (
  input  logic [COLS-1:0] up,
  input  logic [COLS-1:0] mid,
  input  logic [COLS-1:0] dn,
  output logic [COLS-1:0] nxt
);
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int L = (c == 0) ? COLS - 1 : c - 1;
    localparam int R = (c == COLS - 1) ? 0 : c + 1;
    localparam bit EL = (c != 0) || WRAP;
    localparam bit ER = (c != COLS - 1) || WRAP;
    logic [7:0] nb;
    assign nb = {up[c], dn[c], EL & up[L], EL & mid[L], EL & dn[L], ER & up[R], ER & mid[R], ER & dn[R]};
    assign nxt[c] = life_rule(mid[c], 4'($countones(nb)));
  end
endmodule

// File: rtl/life_engine.sv
// life_engine: Game-of-Life grid with button programming and row-serial generation stepping
module life_engine import life_pkg::*; #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int WRAP = 1,
  parameter int CNT_W = 16
) (
  input  logic                            clka,
  input  logic                            rst,
  input  logic [1:0]                      state,
  input  logic                            btn0,
  input  logic                            btn1,
  input  logic                            step,
  output logic [ROWS*COLS-1:0]            grid,
  output logic [$clog2(ROWS*COLS)-1:0]    cell_idx,
  output logic                            busy,
  output logic                            gen_done,
  output logic [CNT_W-1:0]                gen_count,
  output logic                            stable,
  output logic                            extinct
);
  localparam int N = ROWS * COLS;
  localparam int CW = $clog2(N);
  localparam int RW = $clog2(ROWS);
  state_t st;
  logic b0_s, b0_p, b1_s, b1_p, e0, e1, last;
  logic [N-1:0] work, shadow, shadow_nx;
  logic [RW-1:0] row;
  logic [COLS-1:0] up, mid, dn, nxt;
  int ri;
  assign st = state_t'(state);
  assign e0 = b0_s & ~b0_p;
  assign e1 = b1_s & ~b1_p;
  assign ri = int'(row);
  assign last = row == RW'(ROWS - 1);
  assign extinct = ~|grid;
  assign mid = work[ri*COLS +: COLS];
  assign up = ri != 0 ? work[(ri-1)*COLS +: COLS] : (WRAP != 0 ? work[(ROWS-1)*COLS +: COLS] : '0);
  assign dn = ri != ROWS - 1 ? work[(ri+1)*COLS +: COLS] : (WRAP != 0 ? work[COLS-1:0] : '0);
  life_row_eval #(.COLS(COLS), .WRAP(WRAP != 0)) u_row (.up, .mid, .dn, .nxt);
  // shadow buffer with the row under evaluation merged in; the last row's result is the whole new generation
  always_comb begin
    shadow_nx = shadow;
    shadow_nx[ri*COLS +: COLS] = nxt;
  end
  // state actions: IDLE clears like reset, PAUSE freezes, PROGRAM edits and aborts, RUN steps
  always_ff @(posedge clka) begin
    gen_done <= 1'b0;
    if (rst || st == ST_IDLE) begin
      grid <= '0;
      cell_idx <= '0;
      busy <= 1'b0;
      gen_count <= '0;
      stable <= 1'b0;
      {b0_s, b0_p, b1_s, b1_p} <= '0;
      work <= '0;
      shadow <= '0;
      row <= '0;
    end else if (st != ST_PAUSE) begin
      b0_s <= btn0;
      b0_p <= b0_s;
      b1_s <= btn1;
      b1_p <= b1_s;
      if (st == ST_PROGRAM) begin
        busy <= 1'b0;
        if (e0 ^ e1) begin
          grid[cell_idx] <= e0;
          cell_idx <= cell_idx == CW'(N - 1) ? '0 : cell_idx + CW'(1);
          stable <= 1'b0;
        end
      end else if (busy) begin
        shadow <= shadow_nx;
        row <= last ? '0 : row + RW'(1);
        if (last) begin
          grid <= shadow_nx;
          busy <= 1'b0;
          gen_done <= 1'b1;
          gen_count <= gen_count + CNT_W'(1);
          stable <= shadow_nx == grid;
        end
      end else if (step) begin
        work <= grid;
        row <= '0;
        busy <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: directed checks of programming, stepping, pause/abort and edge policy
module tb_life_engine;
  import life_pkg::*;
  logic clka = 1'b0, rst = 1'b1, btn0 = 1'b0, btn1 = 1'b0, step = 1'b0;
  logic [1:0] state = ST_IDLE;
  logic [63:0] g1, g0;
  logic [5:0] idx1, idx0;
  logic [15:0] cnt1, cnt0;
  logic busy1, busy0, done1, done0, stab1, stab0, ext1, ext0;
  int n_chk = 0, n_ok = 0, n_done;
  localparam logic [63:0] BLINK_H = (64'd1 << 25) | (64'd1 << 26) | (64'd1 << 27);
  localparam logic [63:0] BLINK_V = (64'd1 << 18) | (64'd1 << 26) | (64'd1 << 34);
  localparam logic [63:0] BLOCK = (64'd1 << 0) | (64'd1 << 1) | (64'd1 << 8) | (64'd1 << 9);
  localparam logic [63:0] GLIDER = (64'd1 << 37) | (64'd1 << 46) | (64'd1 << 52) | (64'd1 << 53) | (64'd1 << 54);
  localparam logic [63:0] CORNER = (64'd1 << 54) | (64'd1 << 55) | (64'd1 << 62) | (64'd1 << 63);

  life_engine #(.ROWS(8), .COLS(8), .WRAP(1), .CNT_W(16)) d1 (
    .clka(clka), .rst(rst), .state(state), .btn0(btn0), .btn1(btn1), .step(step),
    .grid(g1), .cell_idx(idx1), .busy(busy1), .gen_done(done1), .gen_count(cnt1),
    .stable(stab1), .extinct(ext1));
  life_engine #(.ROWS(8), .COLS(8), .WRAP(0), .CNT_W(16)) d0 (
    .clka(clka), .rst(rst), .state(state), .btn0(btn0), .btn1(btn1), .step(step),
    .grid(g0), .cell_idx(idx0), .busy(busy0), .gen_done(done0), .gen_count(cnt0),
    .stable(stab0), .extinct(ext0));

  always #5 clka = ~clka;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clka);
  endtask

  task automatic press(input logic set);
    btn0 = set;
    btn1 = ~set;
    tick();
    btn0 = 1'b0;
    btn1 = 1'b0;
    tick();
  endtask

  task automatic prog(input logic [63:0] m);
    state = ST_IDLE;
    tick();
    state = ST_PROGRAM;
    for (int i = 0; i < 64; i++) press(m[i]);
    state = ST_RUN;
  endtask

  task automatic step_gen();
    logic seen;
    seen = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = done1;
    end
    check("gen_wait", seen, 1);
  endtask

  task automatic kick();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  initial begin
    tick(2);
    check("rst_grid", g1, 0);
    check("rst_idx", idx1, 0);
    check("rst_flags", {busy1, done1, stab1, ext1}, 4'b0001);
    check("rst_cnt", cnt1, 0);
    rst = 1'b0;
    state = ST_PROGRAM;
    btn0 = 1'b1;
    tick();
    check("btn_lat1", g1, 0);
    tick();
    check("btn_lat2", g1, 1);
    tick(3);
    btn0 = 1'b0;
    tick(2);
    check("hold_grid", g1, 1);
    check("hold_idx", idx1, 1);
    btn0 = 1'b1;
    btn1 = 1'b1;
    tick(3);
    btn0 = 1'b0;
    btn1 = 1'b0;
    tick(2);
    check("both_grid", g1, 1);
    check("both_idx", idx1, 1);
    for (int i = 0; i < 62; i++) press(1'b0);
    check("idx_63", idx1, 63);
    press(1'b1);
    check("set_63", g1, 64'h8000000000000001);
    check("wrap_idx", idx1, 0);
    for (int i = 0; i < 63; i++) press(1'b0);
    check("pre_clear", g1, 64'h8000000000000000);
    press(1'b0);
    check("clear_63", g1, 0);
    check("clear_idx", idx1, 0);
    check("clear_ext", ext1, 1);

    prog(BLINK_H);
    kick();
    check("blink_busy1", busy1, 1);
    tick(7);
    check("blink_busy8", {busy1, done1}, 2'b10);
    check("blink_hold", g1, BLINK_H);
    tick();
    check("blink_done", {busy1, done1}, 2'b01);
    check("blink_v", g1, BLINK_V);
    check("blink_v_nowrap", g0, BLINK_V);
    check("blink_cnt", cnt1, 1);
    tick();
    check("done_pulse", done1, 0);
    step_gen();
    check("blink_h", g1, BLINK_H);
    check("blink_cnt2", cnt1, 2);
    check("blink_stable", stab1, 0);

    prog(BLOCK);
    step_gen();
    check("block_w1", g1, BLOCK);
    check("block_w0", g0, BLOCK);
    check("block_stable", {stab1, stab0}, 2'b11);
    check("block_extinct", {ext1, ext0}, 2'b00);

    prog(GLIDER);
    for (int i = 0; i < 32; i++) step_gen();
    check("glider_w1", g1, GLIDER);
    check("glider_w0", g0, CORNER);
    check("glider_stable", {stab1, stab0}, 2'b01);
    check("glider_cnt", cnt1, 32);

    prog(BLINK_H);
    n_done = 0;
    step = 1'b1;
    for (int i = 0; i < 27; i++) begin
      tick();
      n_done += int'(done1);
    end
    step = 1'b0;
    check("spam_done", n_done, 3);
    check("spam_grid", g1, BLINK_V);
    check("spam_cnt", cnt1, 3);

    prog(BLINK_H);
    kick();
    tick(3);
    state = ST_PAUSE;
    tick(10);
    check("pause_hold", {busy1, done1}, 2'b10);
    state = ST_RUN;
    tick(4);
    check("pause_late", {busy1, done1}, 2'b10);
    tick();
    check("pause_done", done1, 1);
    check("pause_grid", g1, BLINK_V);

    prog(BLINK_H);
    kick();
    tick(3);
    rst = 1'b1;
    tick();
    check("mid_rst_grid", g1, 0);
    check("mid_rst_flags", {busy1, done1, stab1, ext1}, 4'b0001);
    check("mid_rst_cnt", cnt1, 0);
    rst = 1'b0;

    prog(BLINK_H);
    kick();
    tick(2);
    state = ST_IDLE;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_done += int'(done1);
    end
    check("idle_abort_done", n_done, 0);
    check("idle_abort_state", {busy1, cnt1}, 0);
    check("idle_abort_grid", g1, 0);

    prog(BLINK_H);
    kick();
    tick(2);
    state = ST_PROGRAM;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_done += int'(done1);
    end
    check("prog_abort_done", n_done, 0);
    check("prog_abort_grid", g1, BLINK_H);
    check("prog_abort_busy", busy1, 0);
    state = ST_IDLE;
    tick();
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule

// File: doc/life_engine.md
# life_engine

Parametrised Game-of-Life core: holds a ROWS×COLS cell grid, lets the user program it cell-by-cell with two buttons, and advances it one generation per `step` request. It computes one row per cycle into a shadow buffer, then commits the whole generation at once, so `grid` never shows a half-updated state. It is driven by the existing 2-bit control FSM state (IDLE/PROGRAM/RUN/PAUSE) and feeds the display block through `grid`.

## Interface
- `ROWS`, 8, grid height (≥3)
- `COLS`, 8, grid width (≥3)
- `WRAP`, 1, 1 = toroidal edges; 0 = cells outside the grid are dead
- `CNT_W`, 16, generation counter width

Ports (reset is synchronous and active-high):
- `clka`  in  1  sole clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `state`  in  2  control state: 00 IDLE, 01 PROGRAM, 10 RUN, 11 PAUSE
- `btn0`  in  1  program: set current cell (level; rising edge acts)
- `btn1`  in  1  program: clear current cell (level; rising edge acts)
- `step`  in  1  RUN: request one generation (single-cycle pulse)
- `grid`  out  ROWS*COLS  committed grid; cell (r,c) at bit r*COLS+c
- `cell_idx`  out  clog2(ROWS*COLS)  programming cursor
- `busy`  out  1  generation computation in progress
- `gen_done`  out  1  one-cycle pulse when a generation commits
- `gen_count`  out  CNT_W  generations committed since IDLE/reset
- `stable`  out  1  last committed generation equalled its predecessor
- `extinct`  out  1  `grid` is all zero

## Operation
- Reset: `grid`=0, `cell_idx`=0, `busy`=0, `gen_done`=0, `gen_count`=0, `stable`=0, `extinct`=1; button edge registers cleared.
- IDLE: same clearing as reset every cycle.
- PROGRAM: each button is registered and edge-detected. Rising edge of btn0 alone sets `grid[cell_idx]`; of btn1 alone clears it. Either way `cell_idx` then increments, wrapping N-1→0 (N=ROWS*COLS). Rising edges on both buttons in the same cycle: no write, no increment. Held buttons act once.
- RUN: `step` while `busy`=0 latches `grid` into the working copy, clears the row counter, and sets `busy`. Each busy cycle evaluates row r (B3/S23, 8 neighbours, edges per WRAP) into the shadow buffer. After row ROWS-1: shadow→`grid`, `busy`=0, `gen_done`=1 for one cycle, `gen_count`+1 (wraps at 2^CNT_W), `stable`=(new==old). `step` while `busy`=1 is ignored, with no queueing.
- PAUSE: all state holds. A computation in flight freezes and resumes on return to RUN.
- Leaving RUN for IDLE aborts the computation: `busy`=0, no commit. Leaving RUN for PROGRAM also aborts with no commit, and `grid` keeps its old value.
- `extinct` is combinational on `grid`. `stable` is cleared by IDLE/reset and by any PROGRAM write.

## Timing
- Generation latency: `step` at cycle t → `busy` high t+1..t+ROWS → `grid` updates, `gen_done` high at t+ROWS+1.
- A new `step` is accepted at t+ROWS+1 at the earliest, the same cycle as `gen_done`. Max rate is one generation per ROWS+1 cycles.
- Button-to-grid latency: 2 cycles from button rise (sync register + edge/write).
- `rst` dominates `state` in any cycle.

## Structure
- Package `life_pkg`:
  - state encodings `ST_IDLE`, `ST_PROGRAM`, `ST_RUN`, `ST_PAUSE`
  - `life_rule` function (alive, count → next)
- Sub-module `life_row_eval` (combinational): inputs are rows r-1, r, r+1 (COLS bits each) plus WRAP; output is the next-state row. It is instantiated once and time-multiplexed by the row counter.
- The top holds the FSM (IDLE/PROGRAM/RUN/PAUSE actions), button sync/edge, cursor, row counter, shadow buffer, and flags.

## Test plan
- Blinker, 8×8, WRAP=1: program cells 25,26,27; step → `grid` bits {18,26,34} at t+9, `gen_done` pulse, `gen_count`=1. A second step restores {25,26,27}.
- Block still-life at cells 0,1,8,9, both WRAP values: step → `grid` unchanged, `stable`=1, `extinct`=0.
- Glider crossing the edge, WRAP=1 vs WRAP=0: after 32 steps the WRAP=1 glider returns to its start pattern. With WRAP=0 it degrades to the 4-cell block at the corner.
- Programming: hold btn0 for 5 cycles → exactly one set and `cell_idx` 0→1. Both buttons rise together → no change. Cursor at 63 + btn1 → bit 63 clear, `cell_idx`=0.
- `step` repeated every cycle during `busy` → exactly one `gen_done` per ROWS+1 cycles. PAUSE for 10 cycles mid-generation → commit delayed by 10 cycles, result unchanged.
- `rst` asserted at busy cycle 4 → next cycle all outputs at reset values and `grid`=0. IDLE mid-computation → no `gen_done`, `gen_count`=0.
